// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int PC_STEP = 4;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   // Entry layout at the default 32-bit widths; fetch_queue builds the same
   // layout from its own ADDR_W/DATA_W parameters.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/circ_queue.sv
// DEPTH-entry circular buffer with head/tail/count and a one-cycle flush.
module circ_queue #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [63:0]
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  entry_t                 wdata,
   output entry_t                 rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   // Flush wins over push/pop; pointers wrap naturally since DEPTH is 2^n.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[tail] <= wdata;
   end

   assign rdata = mem[head];
   assign full  = (count == (PTR_W + 1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues I-side reads, buffers results
// with their PCs for decode, and handles redirect flush and sticky halt.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              ADDR_W  = 32,
   parameter int              DATA_W  = 32,
   parameter int              DEPTH   = 4,
   parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
   input  logic                   CLK,
   input  logic                   RST,
   output logic                   imemREN,
   output logic [ADDR_W-1:0]      imemaddr,
   input  logic                   ihit,
   input  logic [DATA_W-1:0]      imemload,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_pc,
   input  logic                   halt,
   input  logic                   deq,
   output logic                   valid,
   output logic [DATA_W-1:0]      instr,
   output logic [ADDR_W-1:0]      instr_pc,
   output logic [ADDR_W-1:0]      npc,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output fetch_state_t           fsm_state
);

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc;
   logic              redir, push, pop, empty;
   entry_t            wdata, rdata;

   // Handshake: a word is accepted on any cycle where imemREN and ihit are
   // both high; imemaddr stays on fetch_pc until that cycle.
   assign imemREN  = (state_q == RUN) && !full && !RST;
   assign imemaddr = fetch_pc;
   assign redir    = redirect && (state_q == RUN);
   assign push     = imemREN && ihit && !redirect;
   assign pop      = deq && valid && !redir;
   assign wdata    = '{instr: imemload, pc: fetch_pc};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= RUN;
         fetch_pc <= PC_INIT;
      end else begin
         state_q <= state_d;
         if (redir)     fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
         else if (push) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (halt) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   circ_queue #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .pop   (pop),
      .flush (redir),
      .wdata (wdata),
      .rdata (rdata),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign valid     = !empty;
   assign instr     = rdata.instr;
   assign instr_pc  = rdata.pc;
   assign npc       = rdata.pc + ADDR_W'(PC_STEP);
   assign fsm_state = state_q;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the single-register PC plus request-unit pairing.
- Owns the fetch PC and issues word-aligned reads on the instruction side of the datapath/cache interface.
- Buffers returned instructions, each with its PC, in a DEPTH-entry circular queue that decode drains.
- Supports redirect (branch/jump) with a full flush, and a sticky halt.

Parameters:
ADDR_W, 32, fetch address width in bits
DATA_W, 32, instruction word width in bits
DEPTH, 4, queue entries; power of two, at least 2
PC_INIT, 0, fetch PC loaded on reset; word aligned

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
imemREN  out  1  instruction read request
imemaddr  out  ADDR_W  fetch address, equal to fetch_pc
ihit  in  1  read data valid this cycle
imemload  in  DATA_W  returned instruction
redirect  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored and treated as 0
halt  in  1  stop fetching permanently, until reset
deq  in  1  decode consumes the head entry
valid  out  1  queue not empty
instr  out  DATA_W  head instruction
instr_pc  out  ADDR_W  PC of head instruction
npc  out  ADDR_W  instr_pc + 4, modulo 2^ADDR_W
count  out  $clog2(DEPTH)+1  occupancy
full  out  1  count == DEPTH

Behaviour:
- Reset (RST high at an edge):
  - fetch_pc = PC_INIT; head = tail = count = 0; state = RUN.
  - imemREN is forced to 0 combinationally while RST is high.
  - Resulting outputs: valid=0, full=0, instr/instr_pc = entry 0 contents (don't-care).
  - Reset mid-request drops the request; an ihit in that cycle is ignored.
- States:
  - RUN: fetching.
  - HALTED: no fetch, queue still drains via deq; exited only by RST.
- Requests: imemREN = (state==RUN) && !full && !RST. imemaddr holds fetch_pc stable until the cycle ihit is returned.
- Push: push = imemREN && ihit && !redirect.
  - Writes {imemload, fetch_pc} at tail.
  - tail advances by 1 modulo DEPTH.
  - fetch_pc advances by 4 modulo 2^ADDR_W.
- Pop: pop = deq && valid; head advances by 1 modulo DEPTH. deq while empty is ignored and causes no underflow.
- Count: count changes by push - pop. With push and pop in the same cycle, count is unchanged and both pointers advance.
- When full: imemREN is low, so there is no push even if deq is high that cycle. There is no full-bypass, which means 1 bubble cycle after the queue leaves full.
- Redirect (state RUN):
  - Highest priority. head = tail = count = 0 and fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Any same-cycle ihit data is discarded and deq has no effect.
  - Next cycle imemREN requests the new address, so latency from redirect to the first valid entry is at least 2 cycles.
- Redirect in HALTED: ignored.
- Halt:
  - When halt is high in RUN, the next state is HALTED and imemREN is 0 from the next cycle.
  - A push in the same cycle as halt is still accepted.
  - If redirect and halt arrive together: the flush happens, then the block enters HALTED.
- Outputs: all outputs other than imemREN/imemaddr are derived from registered state only; no combinational path from deq or ihit.

Decomposition:
- Shared package fetch_pkg:
  - fetch_entry_t struct {instr, pc}
  - fetch_state_t enum {RUN, HALTED}
  - PC_STEP = 4
- One natural sub-module: circ_queue, a parametrised DEPTH x entry storage with head/tail/count, push/pop/flush, full/empty.
- fetch_queue keeps the FSM, fetch_pc and request logic.

Test Plan:
- Reset with PC_INIT=0x100, ihit always 1, deq=0 → entries at PCs 0x100, 0x104, 0x108, 0x10C; full=1 after 4 pushes; imemREN=0 thereafter; count=4.
- Full queue, deq=1 for one cycle → count 3, head instr_pc=0x104; next cycle imemREN=1 at imemaddr 0x110.
- Steady ihit=1, deq=1 from half full → count constant; instr_pc increments by 4 each cycle; pointers wrap past DEPTH-1 with no loss.
- Redirect to 0x2003 with ihit=1 and count=3 in the same cycle → next cycle count=0, valid=0, imemaddr=0x2000; first entry pc=0x2000.
- Halt with 2 entries queued → imemREN=0 from the next cycle; both entries drain via deq; later redirect ignored; only RST restores fetch.
- fetch_pc=0xFFFFFFFC with ADDR_W=32 → after push, fetch_pc=0x0; npc of that entry=0x0.
